// File: rtl/hazard_dest_tracker_pkg.sv
// Shared pipeline types: register address, per-stage destination info and the bubble constant.
package riscv_pipe_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic      write;
    reg_addr_t addr;
    logic      mem;
  } dest_info_t;

  localparam reg_addr_t  REG_ZERO    = 5'd0;
  localparam dest_info_t DEST_BUBBLE = '0;

endpackage

// File: rtl/hazard_dest_tracker_if.sv
// Decode-side handshake, per-stage destination outputs and statistics of the destination tracker.
interface hazard_dest_tracker_if
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             id_valid;
  logic             id_write;
  reg_addr_t        id_rd;
  logic             id_mem;
  logic             skip_instr;
  logic             flush;
  logic             id_accept;
  logic             stall_id;
  logic             prev1_write;
  logic             prev2_write;
  logic             prev3_write;
  reg_addr_t        prev1_write_addr;
  reg_addr_t        prev2_write_addr;
  reg_addr_t        prev3_write_addr;
  logic             prev1_mem;
  logic             prev2_mem;
  logic             prev3_mem;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;

  modport master (
    output id_valid, id_write, id_rd, id_mem, skip_instr, flush,
    input  id_accept, stall_id,
    input  prev1_write, prev2_write, prev3_write,
    input  prev1_write_addr, prev2_write_addr, prev3_write_addr,
    input  prev1_mem, prev2_mem, prev3_mem,
    input  stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_write, id_rd, id_mem, skip_instr, flush,
    output id_accept, stall_id,
    output prev1_write, prev2_write, prev3_write,
    output prev1_write_addr, prev2_write_addr, prev3_write_addr,
    output prev1_mem, prev2_mem, prev3_mem,
    output stall_cycles, flush_cycles
  );

endinterface

// File: rtl/hazard_dest_tracker_stage.sv
// One pipeline stage of destination info; registered, 1-cycle latency, never stalls.
module dest_stage_reg
  import riscv_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  dest_info_t d,
  output dest_info_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= DEST_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_dest_tracker.sv
// Tracks EX/MEM/WB destinations for forwarding; accept/stall are combinational, stages shift every cycle.
// Statistics counters are built only when HAZARD_DEST_TRACKER_STATS_EN is defined, otherwise tied to 0.
module hazard_dest_tracker
  import riscv_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_dest_tracker_if.slave bus
);

  logic       accept;
  logic       stall;
  dest_info_t s1_d;
  dest_info_t s1_q;
  dest_info_t s2_q;
  dest_info_t s3_q;

  // Flush wins over the load-use hazard: a squashed instruction never stalls.
  assign accept = bus.id_valid && !bus.skip_instr && !bus.flush;
  assign stall  = bus.id_valid &&  bus.skip_instr && !bus.flush;

  assign bus.id_accept = accept;
  assign bus.stall_id  = stall;

  always_comb begin
    s1_d = DEST_BUBBLE;
    if (accept) begin
      s1_d.write = bus.id_write && (bus.id_rd != REG_ZERO);
      s1_d.addr  = bus.id_rd;
      s1_d.mem   = bus.id_mem && s1_d.write;
    end
  end

  dest_stage_reg u_stage1 (.clk(clk), .rst_n(rst_n), .d(s1_d), .q(s1_q));
  dest_stage_reg u_stage2 (.clk(clk), .rst_n(rst_n), .d(s1_q), .q(s2_q));
  dest_stage_reg u_stage3 (.clk(clk), .rst_n(rst_n), .d(s2_q), .q(s3_q));

  assign bus.prev1_write      = s1_q.write;
  assign bus.prev1_write_addr = s1_q.addr;
  assign bus.prev1_mem        = s1_q.mem;
  assign bus.prev2_write      = s2_q.write;
  assign bus.prev2_write_addr = s2_q.addr;
  assign bus.prev2_mem        = s2_q.mem;
  assign bus.prev3_write      = s3_q.write;
  assign bus.prev3_write_addr = s3_q.addr;
  assign bus.prev3_mem        = s3_q.mem;

`ifdef HAZARD_DEST_TRACKER_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bus.id_valid && bus.flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_cycles = flush_cnt;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Scoreboard bench: driver pushes model expectations per cycle, a monitor pops and compares.
module tb_hazard_dest_tracker;
  import riscv_pipe_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_dest_tracker_if #(.CNT_W(CNT_W)) bus ();
  hazard_dest_tracker #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic             acc;
    logic             stl;
    dest_info_t       p1;
    dest_info_t       p2;
    dest_info_t       p3;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  // Model: most recent destination first; index k is what stage k+1 holds.
  dest_info_t hist[$] = '{DEST_BUBBLE, DEST_BUBBLE, DEST_BUBBLE};
  int         sc_m  = 0;
  int         fc_m  = 0;
  int         cyc_n = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, act, want);
    end
  endtask

  // One clock of stimulus; rst=0 holds reset asserted for this cycle.
  task automatic cyc(input bit rst, input bit v, input bit w, input logic [4:0] rd,
                     input bit m, input bit s, input bit f);
    exp_t       e;
    dest_info_t nd;
    @(negedge clk);
    rst_n          = rst;
    bus.id_valid   = v;
    bus.id_write   = w;
    bus.id_rd      = rd;
    bus.id_mem     = m;
    bus.skip_instr = s;
    bus.flush      = f;
    if (!rst) begin
      hist = '{DEST_BUBBLE, DEST_BUBBLE, DEST_BUBBLE};
      sc_m = 0;
      fc_m = 0;
    end
    e.acc = v && !s && !f;
    e.stl = v && s && !f;
    e.p1  = hist[0];
    e.p2  = hist[1];
    e.p3  = hist[2];
`ifdef HAZARD_DEST_TRACKER_STATS_EN
    e.sc = CNT_W'(sc_m);
    e.fc = CNT_W'(fc_m);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    sb.push_back(e);
    if (rst) begin
      nd = DEST_BUBBLE;
      if (e.acc) begin
        nd.write = w && (rd != 5'd0);
        nd.addr  = rd;
        nd.mem   = m && w && (rd != 5'd0);
      end
      hist.push_front(nd);
      void'(hist.pop_back());
      if (e.stl) sc_m = (sc_m < CNT_MAX) ? sc_m + 1 : CNT_MAX;
      if (v && f) fc_m = (fc_m < CNT_MAX) ? fc_m + 1 : CNT_MAX;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("id_accept", 16'(bus.id_accept), 16'(e.acc));
        check("stall_id", 16'(bus.stall_id), 16'(e.stl));
        check("prev1", 16'({bus.prev1_write, bus.prev1_write_addr, bus.prev1_mem}), 16'(e.p1));
        check("prev2", 16'({bus.prev2_write, bus.prev2_write_addr, bus.prev2_mem}), 16'(e.p2));
        check("prev3", 16'({bus.prev3_write, bus.prev3_write_addr, bus.prev3_mem}), 16'(e.p3));
        check("stall_cycles", 16'(bus.stall_cycles), 16'(e.sc));
        check("flush_cycles", 16'(bus.flush_cycles), 16'(e.fc));
        cyc_n++;
      end
    end
  end

  initial begin : driver
    bus.id_valid = 0; bus.id_write = 0; bus.id_rd = '0;
    bus.id_mem = 0; bus.skip_instr = 0; bus.flush = 0;
    cyc(0, 0, 0, 5'd0, 0, 0, 0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0);
    // add x5 flowing through all three stages
    cyc(1, 1, 1, 5'd5, 0, 0, 0);
    idle(3);
    // lw x7 followed by a dependent instruction that stalls once
    cyc(1, 1, 1, 5'd7, 1, 0, 0);
    cyc(1, 1, 1, 5'd8, 0, 1, 0);
    cyc(1, 1, 1, 5'd8, 0, 0, 0);
    idle(3);
    // load to x0 is masked
    cyc(1, 1, 1, 5'd0, 1, 0, 0);
    idle(1);
    // flush beats skip; flush without a valid instruction is not counted
    cyc(1, 1, 1, 5'd9, 0, 1, 1);
    cyc(1, 0, 1, 5'd9, 0, 0, 1);
    idle(1);
    // fill every stage, then reset mid-stream
    cyc(1, 1, 1, 5'd11, 1, 0, 0);
    cyc(1, 1, 1, 5'd12, 0, 0, 0);
    cyc(1, 1, 1, 5'd13, 1, 0, 0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0);
    cyc(0, 0, 0, 5'd0, 0, 0, 0);
    idle(1);
    // saturating stall counter
    for (int i = 0; i < 20; i++) cyc(1, 1, 1, 5'd3, 0, 1, 0);
    idle(1);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          (($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31))),
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    end
    idle(2);
    @(negedge clk);
    #5;
    check("scoreboard_drain", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_dest_tracker.md
# hazard_dest_tracker

Upstream companion to the forwarding unit in the pipelined RISC-V core. Tracks destination-register information for the three instructions ahead of decode (EX, MEM, WB) and drives the `prev1/2/3_*` inputs of the forwarding unit. Consumes the forwarding unit's `skip_instr` to decide each cycle whether the decode instruction advances or a bubble is inserted into EX. Also produces the decode/fetch stall and the accept strobe.

## Interface
- `CNT_W`, default 16: width of the statistics counters.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  decode stage holds a valid instruction.
- `id_write`  in  1  decode instruction writes `rd`.
- `id_rd`  in  5  decode instruction destination address.
- `id_mem`  in  1  decode instruction is a load; its value arrives from M.
- `skip_instr`  in  1  load-use hazard reported by the forwarding unit for the decode instruction.
- `flush`  in  1  squash the decode instruction (branch resolved taken in EX).
- `id_accept`  out  1  decode instruction enters EX this cycle.
- `stall_id`  out  1  hold the fetch/decode registers this cycle.
- `prev1_write`, `prev2_write`, `prev3_write`  out  1 each  EX/MEM/WB instruction writes a register.
- `prev1_write_addr`, `prev2_write_addr`, `prev3_write_addr`  out  5 each  destination address per stage.
- `prev1_mem`, `prev2_mem`, `prev3_mem`  out  1 each  per-stage load flag.
- `stall_cycles`  out  `CNT_W`  count of load-use bubbles inserted.
- `flush_cycles`  out  `CNT_W`  count of squashed decode instructions.

## Operation
- `id_accept = id_valid && !skip_instr && !flush`. This output is combinational.
- `stall_id = id_valid && skip_instr && !flush`. This output is combinational.
- `flush` has priority over `skip_instr`. A flushed instruction never stalls.
- Stage 1 next value:
  - When `id_accept` is high: `{id_write && id_rd != 0, id_rd, id_mem && id_write && id_rd != 0}`.
  - Otherwise: a bubble `{0, 0, 0}`.
- Writes to x0 are always masked, so x0 is never forwarded and a load to x0 never stalls.
- Stage 2 loads stage 1 and stage 3 loads stage 2 on every clock. The shift is unconditional, because back-end stages never stall.
- Load-use sequence:
  - A load sits in stage 1 with a matching consumer in decode, so `skip_instr` is high.
  - One bubble is inserted. Next cycle the load is in stage 2 with `prev1_mem = 0`, `skip_instr` drops, and the consumer is accepted.
  - The block adds no extra stall logic of its own.
- Statistics:
  - `stall_cycles` increments on each `stall_id` cycle.
  - `flush_cycles` increments on each cycle with `id_valid && flush`.
  - Both counters saturate at all-ones and do not wrap.
- `flush` with `id_valid = 0` inserts a bubble and does not count.

## Timing
- All `prev*` outputs and both counters are registered. All reset to 0 asynchronously on `rst_n` low.
- An accepted instruction appears on `prev1_*` one cycle after acceptance, on `prev2_*` after two cycles, and on `prev3_*` after three.
- Reset asserted mid-operation clears all three stages immediately. The first cycle after release sees an empty pipeline.
- `skip_instr` and `flush` are sampled in the same cycle as `id_valid`. There is no internal FSM beyond the 3-entry shift register and the counters.
- Back-to-back stall requests in consecutive cycles are legal. Each produces one bubble and one count.

## Configuration
- Macro: `HAZARD_DEST_TRACKER_STATS_EN`.
- Defined: both counters are implemented as described.
- Undefined: no counter flops are built, and `stall_cycles`/`flush_cycles` are tied to 0. The ports remain, so integration is unchanged.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - `reg_addr_t` (5-bit logic);
  - struct `dest_info_t {write, addr, mem}`;
  - constant `REG_ZERO = 5'd0`;
  - constant `DEST_BUBBLE` (all-zero `dest_info_t`).
- One sub-module, `dest_stage_reg`: a single `dest_info_t` register with async active-low reset. It is instantiated three times in a chain.
- Acceptance/stall logic and the optional counters live in the top module.

## Test plan
- Reset: drive `rst_n = 0` mid-stream with all stages non-zero -> all `prev*` outputs and both counters read 0 in the same cycle.
- Plain flow: accept `add x5` (write = 1, `rd = 5`) at cycle 0 -> `prev1_write_addr = 5` at cycle 1, `prev2_write_addr = 5` at cycle 2, `prev3_write_addr = 5` at cycle 3, `prev1_write = 0` at cycle 2 if no further instructions.
- Load-use: accept `lw x7` at cycle 0, then drive `skip_instr = 1` for one cycle -> `stall_id = 1` and `id_accept = 0` at cycle 1; stage 1 at cycle 2 is a bubble while `prev2_mem = 1` with `prev2_write_addr = 7`; `stall_cycles = 1`.
- x0 masking: accept `lw x0` -> `prev1_write = 0` and `prev1_mem = 0` next cycle.
- Flush priority: `id_valid = 1`, `skip_instr = 1`, `flush = 1` -> `id_accept = 0`, `stall_id = 0`, bubble inserted; `flush_cycles` increments by 1 and `stall_cycles` is unchanged.
- Saturation (with the macro defined, `CNT_W = 4`): 20 consecutive stall cycles -> `stall_cycles` holds at 15.
